// File: rtl/transfer_control_pkg.sv
// Shared lengths/encodings header for transfer_control: data width,
// transfer mode encodings and FSM state encodings.
package transfer_control_pkg;

  localparam int DATA_LENGTH = 8;

  // cr[1:0] transfer modes
  localparam logic [1:0] MODE_WC_DOWN  = 2'd0;
  localparam logic [1:0] MODE_WC_REF   = 2'd1;
  localparam logic [1:0] MODE_WC_CARRY = 2'd2;
  localparam logic [1:0] MODE_ADDR_REF = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/transfer_control.sv
// Transfer sequencer driving external word/address counters until a
// mode-selected done condition. Optional irq via TRANSFER_CONTROL_IRQ_EN.
module transfer_control #(
  parameter int DATA_LENGTH = transfer_control_pkg::DATA_LENGTH
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic                   cr_wr,
  input  logic                   ref_wr,
  input  logic [DATA_LENGTH-1:0] di,
  input  logic                   start,
  input  logic                   xfer,
  input  logic [DATA_LENGTH-1:0] w_val,
  input  logic [DATA_LENGTH-1:0] a_val,
  input  logic                   w_con,
  input  logic                   a_con,
  output logic                   w_en,
  output logic                   w_inc,
  output logic                   w_dec,
  output logic                   w_cin,
  output logic                   a_en,
  output logic                   a_inc,
  output logic                   a_dec,
  output logic                   a_cin,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             dbg_state
`ifdef TRANSFER_CONTROL_IRQ_EN
  ,
  input  logic                   irq_ack,
  output logic                   irq
`endif
);

  import transfer_control_pkg::*;

  // Handshake: xfer is a one-cycle strobe meaning one word moved this cycle;
  // it is honoured only in RUN and is answered combinationally by en/cin.

  state_e                 state_q, state_d;
  logic [2:0]             cr_q;
  logic [DATA_LENGTH-1:0] ref_q;
  logic [1:0]             mode;
  logic                   addr_down;
  logic                   done_hit;
  logic                   issue;
  logic                   cfg_open;

  // The carry-out of the address counter is not used by any mode.
  logic unused_a_con;
  assign unused_a_con = a_con;

  assign mode      = cr_q[1:0];
  assign addr_down = cr_q[2];
  assign cfg_open  = (state_q != ST_RUN);
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= ST_IDLE;
      cr_q    <= '0;
      ref_q   <= '0;
    end else begin
      state_q <= state_d;
      if (cfg_open && cr_wr) cr_q <= di[2:0];
      if (cfg_open && ref_wr) ref_q <= di;
    end
  end

  // Modes 1-3 look at counter values already updated by an earlier xfer.
  always_comb begin
    done_hit = 1'b0;
    case (mode)
      MODE_WC_DOWN:  done_hit = xfer && (w_val == {{(DATA_LENGTH-1){1'b0}}, 1'b1});
      MODE_WC_REF:   done_hit = (w_val == ref_q);
      MODE_WC_CARRY: done_hit = !w_con;
      MODE_ADDR_REF: done_hit = (a_val == ref_q);
      default:       done_hit = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (done_hit) state_d = ST_DONE;
      ST_DONE: if (start) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // A reset in the same cycle suppresses the counter command.
  assign issue = (state_q == ST_RUN) && xfer && !res;

  always_comb begin
    w_en  = 1'b0;
    w_inc = 1'b0;
    w_dec = 1'b0;
    w_cin = 1'b1;
    a_en  = 1'b0;
    a_inc = 1'b0;
    a_dec = 1'b0;
    a_cin = 1'b1;
    if (issue) begin
      w_en  = 1'b1;
      w_cin = 1'b0;
      w_dec = (mode == MODE_WC_DOWN);
      w_inc = (mode != MODE_WC_DOWN);
      a_en  = 1'b1;
      a_cin = 1'b0;
      a_dec = addr_down;
      a_inc = !addr_down;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

`ifdef TRANSFER_CONTROL_IRQ_EN
  // Acknowledge wins over a simultaneous RUN->DONE set.
  always_ff @(posedge clk) begin
    if (res) begin
      irq <= 1'b0;
    end else if (irq_ack) begin
      irq <= 1'b0;
    end else if (state_q == ST_RUN && state_d == ST_DONE) begin
      irq <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_transfer_control.sv
// Self-checking bench for transfer_control: a reference model predicts outputs
// per cycle into exp_q; a bench-side counter model feeds w_val/a_val/w_con.
module tb_transfer_control;

  localparam int DW = 8;
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2;

  logic          clk = 1'b0;
  logic          res, cr_wr, ref_wr, start, xfer, w_con, a_con;
  logic [DW-1:0] di, w_val, a_val;
  logic          w_en, w_inc, w_dec, w_cin, a_en, a_inc, a_dec, a_cin;
  logic          busy, done;
  logic [1:0]    dbg_state;
  logic          irq_bit;
`ifdef TRANSFER_CONTROL_IRQ_EN
  logic          irq, irq_ack;
  assign irq_bit = irq;
`else
  assign irq_bit = 1'b0;
`endif

  always #5 clk = ~clk;

  transfer_control #(.DATA_LENGTH(DW)) dut (
    .clk(clk), .res(res), .cr_wr(cr_wr), .ref_wr(ref_wr), .di(di),
    .start(start), .xfer(xfer), .w_val(w_val), .a_val(a_val),
    .w_con(w_con), .a_con(a_con),
    .w_en(w_en), .w_inc(w_inc), .w_dec(w_dec), .w_cin(w_cin),
    .a_en(a_en), .a_inc(a_inc), .a_dec(a_dec), .a_cin(a_cin),
    .busy(busy), .done(done), .dbg_state(dbg_state)
`ifdef TRANSFER_CONTROL_IRQ_EN
    , .irq_ack(irq_ack), .irq(irq)
`endif
  );

  // {busy, done, w_en, w_inc, w_dec, w_cin, a_en, a_inc, a_dec, a_cin, irq}
  logic [10:0] act_vec;
  assign act_vec = {busy, done, w_en, w_inc, w_dec, w_cin,
                    a_en, a_inc, a_dec, a_cin, irq_bit};

  logic [10:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_wdec   = 0;

  // Reference model state
  logic [1:0]    m_state;
  logic [2:0]    m_cr;
  logic [DW-1:0] m_ref, m_w, m_a;
  logic          m_wcon, m_acon, m_irq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] model_out(input logic r, input logic x);
    logic act;
    act = (m_state == S_RUN) && x && !r;
    return {m_state == S_RUN, m_state == S_DONE,
            act, act && (m_cr[1:0] != 2'd0), act && (m_cr[1:0] == 2'd0), !act,
            act, act && !m_cr[2], act && m_cr[2], !act, m_irq};
  endfunction

  task automatic set_counters(input logic [DW-1:0] w, input logic [DW-1:0] a);
    m_w = w; m_a = a; m_wcon = 1'b1; m_acon = 1'b1;
  endtask

  task automatic step(input string tag, input logic s, input logic x,
                      input logic cw, input logic rw, input logic [DW-1:0] d,
                      input logic r, input logic ack);
    logic [10:0] e;
    logic        hit;
    logic [1:0]  ns;
    @(negedge clk);
    start = s; xfer = x; cr_wr = cw; ref_wr = rw; di = d; res = r;
    w_val = m_w; a_val = m_a; w_con = m_wcon; a_con = m_acon;
`ifdef TRANSFER_CONTROL_IRQ_EN
    irq_ack = ack;
`endif
    exp_q.push_back(model_out(r, x));
    #1;
    e = exp_q.pop_front();
    check(tag, {21'd0, act_vec}, {21'd0, e});
    if (w_dec) n_wdec++;
    @(posedge clk);
    case (m_cr[1:0])
      2'd0:    hit = x && (m_w == 8'd1);
      2'd1:    hit = (m_w == m_ref);
      2'd2:    hit = !m_wcon;
      default: hit = (m_a == m_ref);
    endcase
    ns = m_state;
    if (m_state == S_IDLE && s) ns = S_RUN;
    else if (m_state == S_RUN && hit) ns = S_DONE;
    else if (m_state == S_DONE && s) ns = S_RUN;
    if (r) begin
      m_irq = 1'b0;
    end else if (ack && (m_irq || (m_state == S_RUN && ns == S_DONE))) begin
      m_irq = 1'b0;
    end else if (m_state == S_RUN && ns == S_DONE) begin
`ifdef TRANSFER_CONTROL_IRQ_EN
      m_irq = 1'b1;
`endif
    end
    if (r) begin
      m_state = S_IDLE; m_cr = '0; m_ref = '0;
    end else begin
      if (m_state != S_RUN && cw) m_cr = d[2:0];
      if (m_state != S_RUN && rw) m_ref = d;
      m_state = ns;
    end
    // Bench-side counters follow the predicted commands.
    if (e[8]) begin
      if (e[7]) begin m_wcon = (m_w != 8'hFF); m_w = m_w + 8'd1; end
      else      begin m_wcon = (m_w != 8'h00); m_w = m_w - 8'd1; end
    end else m_wcon = 1'b1;
    if (e[4]) begin
      if (e[3]) begin m_acon = (m_a != 8'hFF); m_a = m_a + 8'd1; end
      else      begin m_acon = (m_a != 8'h00); m_a = m_a - 8'd1; end
    end else m_acon = 1'b1;
  endtask

  initial begin
    // Clock/reset block
    res = 1'b1; cr_wr = 0; ref_wr = 0; start = 0; xfer = 0; di = '0;
    w_val = '0; a_val = '0; w_con = 1; a_con = 1;
`ifdef TRANSFER_CONTROL_IRQ_EN
    irq_ack = 0;
`endif
    m_state = S_IDLE; m_cr = '0; m_ref = '0; m_irq = 1'b0;
    set_counters(8'd0, 8'd0);
    repeat (2) @(posedge clk);

    step("reset_hold", 1, 1, 1, 1, 8'hFF, 1, 0);
    step("reset_idle", 0, 1, 0, 0, 8'h00, 0, 0);
    check("reset_dbg_state", {30'd0, dbg_state}, 32'd0);

    // Mode 0: word count down 3->2->1
    step("m0_cr", 0, 0, 1, 0, 8'h00, 0, 0);
    set_counters(8'd3, 8'h20);
    n_wdec = 0;
    step("m0_start", 1, 0, 0, 0, 8'h00, 0, 0);
    step("m0_x1", 0, 1, 0, 0, 8'h00, 0, 0);
    step("m0_x2", 0, 1, 0, 0, 8'h00, 0, 0);
    step("m0_x3", 0, 1, 0, 0, 8'h00, 0, 0);
    step("m0_done", 0, 0, 0, 0, 8'h00, 0, 0);
    check("m0_wdec_count", n_wdec, 3);
    check("m0_done_flag", {30'd0, busy, done}, 32'd1);
`ifdef TRANSFER_CONTROL_IRQ_EN
    step("irq_held", 0, 0, 0, 0, 8'h00, 0, 0);
    step("irq_ack", 0, 0, 0, 0, 8'h00, 0, 1);
    step("irq_clear", 0, 0, 0, 0, 8'h00, 0, 0);
`endif

    // Mode 1: count up to ref 0x05, restarted from DONE
    step("m1_cr", 0, 0, 1, 0, 8'h01, 0, 0);
    step("m1_ref", 0, 0, 0, 1, 8'h05, 0, 0);
    set_counters(8'd3, 8'h40);
    step("m1_start", 1, 0, 0, 0, 8'h00, 0, 0);
    step("m1_x3", 0, 1, 0, 0, 8'h00, 0, 0);
    step("m1_x4", 0, 1, 0, 0, 8'h00, 0, 0);
    step("m1_at5", 0, 0, 0, 0, 8'h00, 0, 0);
    step("m1_done_xfer", 0, 1, 0, 0, 8'h00, 0, 0);

    // Mode 2: 0 alone is not done; FF->00 carry ends the transfer
    step("m2_cr", 0, 0, 1, 0, 8'h02, 0, 0);
    set_counters(8'h00, 8'h00);
    step("m2_start", 1, 0, 0, 0, 8'h00, 0, 0);
    step("m2_zero", 0, 0, 0, 0, 8'h00, 0, 0);
    step("m2_zero_busy", 0, 0, 0, 0, 8'h00, 0, 0);
    set_counters(8'hFF, 8'h00);
    step("m2_x_ff", 0, 1, 0, 0, 8'h00, 0, 0);
    step("m2_carry", 0, 0, 0, 0, 8'h00, 0, 0);
    step("m2_done", 0, 0, 0, 0, 8'h00, 0, 0);

    // Mode 3 with address decrement to ref 0x10
    step("m3_cr", 0, 0, 1, 0, 8'h07, 0, 0);
    step("m3_ref", 0, 0, 0, 1, 8'h10, 0, 0);
    set_counters(8'h00, 8'h12);
    step("m3_start", 1, 0, 0, 0, 8'h00, 0, 0);
    step("m3_x12", 0, 1, 0, 0, 8'h00, 0, 0);
    step("m3_x11", 0, 1, 0, 0, 8'h00, 0, 0);
    step("m3_at10", 0, 0, 0, 0, 8'h00, 0, 0);
    step("m3_done", 0, 0, 0, 0, 8'h00, 0, 0);

    // cr_wr during RUN is ignored; reset mid-transfer with xfer high
    step("rr_cr", 0, 0, 1, 0, 8'h04, 0, 0);
    set_counters(8'h50, 8'h50);
    step("rr_start", 1, 0, 0, 0, 8'h00, 0, 0);
    step("rr_crwr_run", 0, 0, 1, 0, 8'h01, 0, 0);
    step("rr_x_mode0", 0, 1, 0, 0, 8'h00, 0, 0);
    step("rr_res_xfer", 0, 1, 0, 0, 8'h00, 1, 0);
    step("rr_idle", 0, 1, 0, 0, 8'h00, 0, 0);
    check("rr_dbg_state", {30'd0, dbg_state}, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 80; i++) begin
      step("rand",
           $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
           8'($urandom_range(0, 255)), $urandom_range(0, 24) == 0,
           $urandom_range(0, 3) == 0);
    end

    check("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/transfer_control.md
TRANSFER_CONTROL -- requirements
Module: transfer_control

Interface
REQ-001 Parameter DATA_LENGTH, default `DATA_LENGTH (shared lengths header); width of data, count, address and reference values.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 res  in  1  reset; synchronous, active-high.
REQ-004 cr_wr  in  1  load control register from di[2:0].
REQ-005 ref_wr  in  1  load reference register from di.
REQ-006 di  in  DATA_LENGTH  data bus.
REQ-007 start  in  1  begin a transfer.
REQ-008 xfer  in  1  one word transferred this cycle.
REQ-009 w_val, a_val  in  DATA_LENGTH each  current word and address counter values.
REQ-010 w_con, a_con  in  1 each  counter carry-out, negated (0 = carry/borrow).
REQ-011 w_en, w_inc, w_dec, w_cin  out  1 each  word counter controls; w_cin negated.
REQ-012 a_en, a_inc, a_dec, a_cin  out  1 each  address counter controls; a_cin negated.
REQ-013 busy  out  1  high in RUN.
REQ-014 done  out  1  high in DONE.

Function
REQ-015 Control register cr[2:0]: cr[1:0] = mode, cr[2] = address direction (0 inc, 1 dec).
REQ-016 Modes: 0 word count down, done when xfer accepted with w_val == 1; 1 word count up, done when w_val == ref in RUN; 2 word count up, done when w_con sampled 0 in RUN; 3 word count up, done when a_val == ref in RUN.
REQ-017 States: IDLE, RUN, DONE; registered one-hot or binary, encoding from shared header.
REQ-018 IDLE: start -> RUN next cycle; other inputs except cr_wr/ref_wr ignored.
REQ-019 RUN: xfer drives w_en=1, a_en=1, w_cin=0, a_cin=0 combinationally in the same cycle; w_inc/w_dec per mode (dec in mode 0 only), a_inc/a_dec per cr[2].
REQ-020 RUN without xfer: w_cin=a_cin=1, w_en=a_en=0.
REQ-021 Done detection -> DONE on the next edge; modes 1-3 compare the value already updated by the counter (one cycle after xfer).
REQ-022 Done condition and xfer in same cycle: that xfer is still issued to the counters; then DONE.
REQ-023 DONE: all counter controls inactive (en=0, inc=dec=0, cin=1); xfer ignored; start -> RUN with done cleared.
REQ-024 start in RUN ignored; cr_wr/ref_wr in RUN ignored; accepted in IDLE and DONE.
REQ-025 Mode 2 wrap: w_con low after increment from all-ones ends transfer; counter value 0 is not itself a done condition.
REQ-026 All compares are full DATA_LENGTH unsigned equality; no arithmetic in this block.

Reset
REQ-027 res in any state -> IDLE next edge; cr=0, ref=0, busy=0, done=0, irq=0; counter controls inactive.
REQ-028 res overrides start, cr_wr, ref_wr, xfer in the same cycle; mid-transfer reset issues no further counter commands.

Configuration
REQ-029 Macro TRANSFER_CONTROL_IRQ_EN defined: adds irq out 1 and irq_ack in 1; irq set on RUN->DONE, held until irq_ack (ack wins over simultaneous set).
REQ-030 Macro undefined: ports irq/irq_ack absent; behaviour otherwise identical.

Structure
REQ-031 Shared header holds DATA_LENGTH, mode encodings (MODE_WC_DOWN, MODE_WC_REF, MODE_WC_CARRY, MODE_ADDR_REF) and state encodings.
REQ-032 No sub-module; single module with state register, control/reference registers, done-select logic.

Verification (DATA_LENGTH=8)
REQ-033 Mode 0, w_val 3->2->1, three xfer pulses -> w_dec asserted three times, done=1 one cycle after third xfer, busy=0.
REQ-034 Mode 1, ref=0x05, w_val counting 0x03..0x05 -> done the cycle after w_val reads 0x05; further xfer produces no w_en.
REQ-035 Mode 2, w_val=0xFF, xfer, then w_con=0 -> DONE next edge; mode 3 with cr[2]=1, ref=0x10, a_val reaching 0x10 -> DONE, a_dec used throughout.
REQ-036 res asserted in RUN with xfer high -> next cycle IDLE, all en=0, cin=1, done=0; cr_wr during RUN leaves cr unchanged.
REQ-037 With TRANSFER_CONTROL_IRQ_EN: done -> irq=1, held until irq_ack, clears next edge; start from DONE re-enters RUN with done=0.
